fp_csr_unit: RTL and testbench



---
 rtl/fp_csr_pkg.sv | 50 +++++
 rtl/fp_rm_resolve.sv | 21 ++
 rtl/fp_csr_unit.sv | 146 ++++++++++++++
 tb/tb_fp_csr_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_csr_pkg.sv
// Shared types and constants for the floating-point CSR unit: rounding modes,
// CSR access opcodes, fflags bit positions and the fcsr/frm/fflags addresses.
package fp_csr_pkg;

  localparam int          XLEN_DEF        = 32;
  localparam logic [11:0] FFLAGS_ADDR_DEF = 12'h001;
  localparam logic [11:0] FRM_ADDR_DEF    = 12'h002;
  localparam logic [11:0] FCSR_ADDR_DEF   = 12'h003;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } rm_e;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Applies a CSR op to the packed {frm, fflags} byte; bits outside mask keep their old value.
  function automatic logic [7:0] csr_apply(csr_op_e op, logic [7:0] oldv,
                                           logic [7:0] bits, logic [7:0] mask);
    logic [7:0] res;
    case (op)
      CSR_WRITE: res = bits;
      CSR_SET:   res = oldv | bits;
      CSR_CLEAR: res = oldv & ~bits;
      default:   res = oldv;
    endcase
    return (oldv & ~mask) | (res & mask);
  endfunction

endpackage

// File: rtl/fp_rm_resolve.sv
// Resolves an instruction's rounding-mode field against frm and flags reserved
// encodings; an illegal result is forced to RNE so the FMA never sees it.
module fp_rm_resolve
  import fp_csr_pkg::*;
(
  input  logic [2:0] inst_rm_i,
  input  logic [2:0] frm_i,
  output logic [2:0] rm_o,
  output logic       illegal_o
);

  logic [2:0] selRm;

  assign selRm = (inst_rm_i == DYN) ? frm_i : inst_rm_i;

  always_comb begin
    illegal_o = (selRm == 3'b101) || (selRm == 3'b110) || (selRm == 3'b111);
    rm_o      = illegal_o ? RNE : selRm;
  end

endmodule

// File: rtl/fp_csr_unit.sv
// Floating-point CSR unit: owns fcsr (frm + sticky fflags), resolves rounding
// modes for the FMA, accrues exception flags and serves CSR accesses.
module fp_csr_unit
  import fp_csr_pkg::*;
#(
  parameter int          XLEN        = XLEN_DEF,
  parameter logic [11:0] FFLAGS_ADDR = FFLAGS_ADDR_DEF,
  parameter logic [11:0] FRM_ADDR    = FRM_ADDR_DEF,
  parameter logic [11:0] FCSR_ADDR   = FCSR_ADDR_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      Inst_rm_i,
  output logic [2:0]      Rounding_mode_o,
  output logic            Rm_illegal_o,
  input  logic            Accrue_valid_i,
  input  logic            NV_i,
  input  logic            DZ_i,
  input  logic            OF_i,
  input  logic            UF_i,
  input  logic            NX_i,
  input  logic            Csr_req_i,
  input  logic [1:0]      Csr_op_i,
  input  logic [11:0]     Csr_addr_i,
  input  logic [XLEN-1:0] Csr_wdata_i,
  output logic            Csr_ready_o,
  output logic            Csr_rvalid_o,
  output logic [XLEN-1:0] Csr_rdata_o,
  output logic            Csr_illegal_o,
  output logic [2:0]      Frm_o,
  output logic [4:0]      Fflags_o
);

  state_e          state_q;
  logic            ready_q;
  logic            rvalid_q;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      frm_q, frm_d;
  logic [4:0]      fflags_q, fflags_d;

  csr_op_e    csrOp;
  logic       accept;
  logic [4:0] accrued;
  logic [7:0] fieldMask;
  logic [7:0] fieldBits;
  logic [7:0] fieldsNew;
  logic       unusedWdata;

  assign csrOp       = csr_op_e'(Csr_op_i);
  assign accept      = (state_q == IDLE) && ready_q && Csr_req_i && (csrOp != CSR_NONE);
  assign unusedWdata = ^Csr_wdata_i[XLEN-1:8];

  fp_rm_resolve u_rm_resolve (
    .inst_rm_i (Inst_rm_i),
    .frm_i     (frm_q),
    .rm_o      (Rounding_mode_o),
    .illegal_o (Rm_illegal_o)
  );

  always_comb begin
    accrued = '0;
    if (Accrue_valid_i) begin
      accrued[FLAG_NV] = NV_i;
      accrued[FLAG_DZ] = DZ_i;
      accrued[FLAG_OF] = OF_i;
      accrued[FLAG_UF] = UF_i;
      accrued[FLAG_NX] = NX_i;
    end
  end

  // Each address maps onto a slice of the packed {frm, fflags} byte; the read
  // value is captured before the update so same-cycle accrual never shows up in it.
  always_comb begin
    fieldMask = '0;
    fieldBits = '0;
    rdata_d   = '0;
    illegal_d = 1'b0;
    case (Csr_addr_i)
      FFLAGS_ADDR: begin
        fieldMask = 8'h1F;
        fieldBits = {3'b000, Csr_wdata_i[4:0]};
        rdata_d   = XLEN'(fflags_q);
      end
      FRM_ADDR: begin
        fieldMask = 8'hE0;
        fieldBits = {Csr_wdata_i[2:0], 5'b00000};
        rdata_d   = XLEN'(frm_q);
      end
      FCSR_ADDR: begin
        fieldMask = 8'hFF;
        fieldBits = Csr_wdata_i[7:0];
        rdata_d   = XLEN'({frm_q, fflags_q});
      end
      default: illegal_d = 1'b1;
    endcase
    fieldsNew = accept ? csr_apply(csrOp, {frm_q, fflags_q}, fieldBits, fieldMask)
                       : {frm_q, fflags_q};
    frm_d     = fieldsNew[7:5];
    fflags_d  = fieldsNew[4:0] | accrued;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      frm_q     <= '0;
      fflags_q  <= '0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= RESP;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          rvalid_q  <= 1'b0;
          rdata_q   <= '0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  // A reset arriving during the response cycle suppresses the pending response.
  assign Csr_rvalid_o  = rvalid_q & ~rst_i;
  assign Csr_ready_o   = ready_q;
  assign Csr_rdata_o   = rdata_q;
  assign Csr_illegal_o = illegal_q;
  assign Frm_o         = frm_q;
  assign Fflags_o      = fflags_q;

endmodule

// File: tb/tb_fp_csr_unit.sv
// Self-checking bench for fp_csr_unit: CSR responses are scored against a queue
// of expected {illegal, rdata} pushed when each access is driven.
module tb_fp_csr_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  Inst_rm_i;
  logic [2:0]  Rounding_mode_o;
  logic        Rm_illegal_o;
  logic        Accrue_valid_i;
  logic        NV_i, DZ_i, OF_i, UF_i, NX_i;
  logic        Csr_req_i;
  logic [1:0]  Csr_op_i;
  logic [11:0] Csr_addr_i;
  logic [31:0] Csr_wdata_i;
  logic        Csr_ready_o;
  logic        Csr_rvalid_o;
  logic [31:0] Csr_rdata_o;
  logic        Csr_illegal_o;
  logic [2:0]  Frm_o;
  logic [4:0]  Fflags_o;

  int total = 0;
  int bad   = 0;
  logic [32:0] expQ[$];

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  fp_csr_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .Inst_rm_i       (Inst_rm_i),
    .Rounding_mode_o (Rounding_mode_o),
    .Rm_illegal_o    (Rm_illegal_o),
    .Accrue_valid_i  (Accrue_valid_i),
    .NV_i            (NV_i),
    .DZ_i            (DZ_i),
    .OF_i            (OF_i),
    .UF_i            (UF_i),
    .NX_i            (NX_i),
    .Csr_req_i       (Csr_req_i),
    .Csr_op_i        (Csr_op_i),
    .Csr_addr_i      (Csr_addr_i),
    .Csr_wdata_i     (Csr_wdata_i),
    .Csr_ready_o     (Csr_ready_o),
    .Csr_rvalid_o    (Csr_rvalid_o),
    .Csr_rdata_o     (Csr_rdata_o),
    .Csr_illegal_o   (Csr_illegal_o),
    .Frm_o           (Frm_o),
    .Fflags_o        (Fflags_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one access, waits (bounded) for acceptance and returns what the DUT
  // presents in the response cycle; leaves the bench at posedge+1 of RESP.
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wdata, output logic [32:0] obs,
                            output logic ok);
    int n = 0;
    Csr_req_i   = 1'b1;
    Csr_op_i    = op;
    Csr_addr_i  = addr;
    Csr_wdata_i = wdata;
    while (!Csr_ready_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    @(posedge clk_i); #1;
    Csr_req_i = 1'b0;
    Csr_op_i  = 2'b00;
    obs = {Csr_illegal_o, Csr_rdata_o};
    ok  = Csr_rvalid_o && (n < 10);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    Inst_rm_i = 3'b000;
    Accrue_valid_i = 0; NV_i = 0; DZ_i = 0; OF_i = 0; UF_i = 0; NX_i = 0;
    Csr_req_i = 0; Csr_op_i = 0; Csr_addr_i = 0; Csr_wdata_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (Csr_ready_o !== 1'b0 || Csr_rvalid_o !== 1'b0 || Csr_rdata_o !== 32'h0 || Csr_illegal_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got ready=%b rvalid=%b rdata=%h ill=%b want 0/0/0/0",
               Csr_ready_o, Csr_rvalid_o, Csr_rdata_o, Csr_illegal_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    total++;
    if (Csr_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready got %b want 1", Csr_ready_o);
    end
    total++;
    if (Frm_o !== 3'b000 || Fflags_o !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL reset_regs got frm=%b fflags=%b want 000/00000", Frm_o, Fflags_o);
    end
    Inst_rm_i = 3'b111;
    #1;
    total++;
    if (Rounding_mode_o !== 3'b000 || Rm_illegal_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_dyn_rm got rm=%b ill=%b want 000/0", Rounding_mode_o, Rm_illegal_o);
    end
  endtask

  task automatic test_fcsr_write();
    logic [32:0] obs, exp;
    logic ok;
    expQ.push_back({1'b0, 32'h0});
    csr_access(OP_WRITE, 12'h003, 32'h000000E5, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++;
      $display("[TB] FAIL fcsr_write_resp got ok=%b obs=%h want ok=1 obs=%h", ok, obs, exp);
    end
    total++;
    if (Frm_o !== 3'b111 || Fflags_o !== 5'b00101) begin
      bad++;
      $display("[TB] FAIL fcsr_write_regs got frm=%b fflags=%b want 111/00101", Frm_o, Fflags_o);
    end
    Inst_rm_i = 3'b111;
    #1;
    total++;
    if (Rm_illegal_o !== 1'b1 || Rounding_mode_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL dyn_bad_frm got rm=%b ill=%b want 000/1", Rounding_mode_o, Rm_illegal_o);
    end
    Inst_rm_i = 3'b011;
    #1;
    total++;
    if (Rm_illegal_o !== 1'b0 || Rounding_mode_o !== 3'b011) begin
      bad++;
      $display("[TB] FAIL static_rup got rm=%b ill=%b want 011/0", Rounding_mode_o, Rm_illegal_o);
    end
    Inst_rm_i = 3'b101;
    #1;
    total++;
    if (Rm_illegal_o !== 1'b1 || Rounding_mode_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL static_101 got rm=%b ill=%b want 000/1", Rounding_mode_o, Rm_illegal_o);
    end
    // A set with no bits reads fcsr back without changing it.
    expQ.push_back({1'b0, 32'h000000E5});
    csr_access(OP_SET, 12'h003, 32'h0, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp || Frm_o !== 3'b111 || Fflags_o !== 5'b00101) begin
      bad++;
      $display("[TB] FAIL fcsr_readback got ok=%b obs=%h frm=%b ff=%b want obs=%h 111/00101",
               ok, obs, Frm_o, Fflags_o, exp);
    end
  endtask

  task automatic test_frm_access();
    logic [32:0] obs, exp;
    logic ok;
    expQ.push_back({1'b0, 32'h7});
    csr_access(OP_WRITE, 12'h002, 32'hFFFFFF02, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp || Frm_o !== 3'b010 || Fflags_o !== 5'b00101) begin
      bad++;
      $display("[TB] FAIL frm_write got ok=%b obs=%h frm=%b ff=%b want obs=%h 010/00101",
               ok, obs, Frm_o, Fflags_o, exp);
    end
    Inst_rm_i = 3'b111;
    #1;
    total++;
    if (Rm_illegal_o !== 1'b0 || Rounding_mode_o !== 3'b010) begin
      bad++;
      $display("[TB] FAIL dyn_rdn got rm=%b ill=%b want 010/0", Rounding_mode_o, Rm_illegal_o);
    end
    expQ.push_back({1'b0, 32'h2});
    csr_access(OP_CLEAR, 12'h002, 32'h2, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp || Frm_o !== 3'b000) begin
      bad++;
      $display("[TB] FAIL frm_clear got ok=%b obs=%h frm=%b want obs=%h frm=000", ok, obs, Frm_o, exp);
    end
  endtask

  task automatic test_accrual();
    logic [32:0] obs, exp;
    logic ok;
    expQ.push_back({1'b0, 32'h05});
    csr_access(OP_WRITE, 12'h001, 32'h0, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp || Fflags_o !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL fflags_zero got ok=%b obs=%h ff=%b want obs=%h ff=00000", ok, obs, Fflags_o, exp);
    end
    Accrue_valid_i = 1; NX_i = 1;
    @(posedge clk_i); #1;
    NX_i = 0; NV_i = 1; OF_i = 1;
    @(posedge clk_i); #1;
    Accrue_valid_i = 0; NV_i = 0; OF_i = 0;
    total++;
    if (Fflags_o !== 5'b10101) begin
      bad++;
      $display("[TB] FAIL accrue_sticky got %b want 10101", Fflags_o);
    end
    DZ_i = 1; UF_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    DZ_i = 0; UF_i = 0;
    total++;
    if (Fflags_o !== 5'b10101) begin
      bad++;
      $display("[TB] FAIL accrue_gated got %b want 10101", Fflags_o);
    end
  endtask

  task automatic test_clear_with_accrual();
    logic [32:0] obs, exp;
    logic ok;
    Accrue_valid_i = 1; UF_i = 1;
    expQ.push_back({1'b0, 32'h15});
    csr_access(OP_CLEAR, 12'h001, 32'h1F, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++;
      $display("[TB] FAIL clear_rdata got ok=%b obs=%h want obs=%h", ok, obs, exp);
    end
    total++;
    if (Fflags_o !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL clear_keeps_accrual got %b want 00010", Fflags_o);
    end
    Accrue_valid_i = 0; UF_i = 0;
  endtask

  task automatic test_back_to_back();
    logic [32:0] obs, exp;
    logic ok;
    expQ.push_back({1'b1, 32'h0});
    csr_access(OP_WRITE, 12'h7C0, 32'hFF, obs, ok);
    exp = expQ.pop_front();
    total++;
    if (!ok || obs !== exp || Frm_o !== 3'b000 || Fflags_o !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL unknown_addr got ok=%b obs=%h frm=%b ff=%b want obs=%h 000/00010",
               ok, obs, Frm_o, Fflags_o, exp);
    end
    // Second request raised during RESP must wait for the next IDLE cycle.
    expQ.push_back({1'b0, 32'h02});
    Csr_req_i = 1; Csr_op_i = OP_SET; Csr_addr_i = 12'h001; Csr_wdata_i = 32'h01;
    total++;
    if (Csr_ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resp_not_ready got %b want 0", Csr_ready_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (Csr_rvalid_o !== 1'b0 || Csr_ready_o !== 1'b1 || Fflags_o !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL held_req_ignored got rvalid=%b ready=%b ff=%b want 0/1/00010",
               Csr_rvalid_o, Csr_ready_o, Fflags_o);
    end
    @(posedge clk_i); #1;
    Csr_req_i = 0; Csr_op_i = 0;
    exp = expQ.pop_front();
    obs = {Csr_illegal_o, Csr_rdata_o};
    total++;
    if (Csr_rvalid_o !== 1'b1 || obs !== exp || Fflags_o !== 5'b00011) begin
      bad++;
      $display("[TB] FAIL held_req_accepted got rvalid=%b obs=%h ff=%b want 1 obs=%h ff=00011",
               Csr_rvalid_o, obs, Fflags_o, exp);
    end
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    int seen = 0;
    while (!Csr_ready_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    Csr_req_i = 1; Csr_op_i = OP_WRITE; Csr_addr_i = 12'h003; Csr_wdata_i = 32'hFF;
    @(posedge clk_i); #1;
    rst_i = 1; Csr_req_i = 0; Csr_op_i = 0;
    #1;
    if (Csr_rvalid_o !== 1'b0) seen++;
    @(posedge clk_i); #1;
    rst_i = 0;
    if (Csr_rvalid_o !== 1'b0) seen++;
    total++;
    if (Frm_o !== 3'b000 || Fflags_o !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL reset_mid_regs got frm=%b ff=%b want 000/00000", Frm_o, Fflags_o);
    end
    repeat (2) begin
      @(posedge clk_i); #1;
      if (Csr_rvalid_o !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || n >= 10) begin
      bad++;
      $display("[TB] FAIL reset_mid_no_resp got rvalid_samples=%0d wait=%0d want 0 and <10", seen, n);
    end
    total++;
    if (Csr_ready_o !== 1'b1 || expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL post_reset_idle got ready=%b pending=%0d want 1/0", Csr_ready_o, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_fcsr_write();
    test_frm_access();
    test_accrual();
    test_clear_with_accrual();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
